// File: rtl/ann_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ann_ctrl_pkg
// Brief    : Shared state encoding and constants for the ANN load sequencer.
// Revision : 1.0
// ============================================================================
package ann_ctrl_pkg;

    localparam int DEFAULT_TIMEOUT = 1023;
    localparam int COEF_SEL_IMAGE  = 0;
    localparam int ADDR_W          = 10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_XFER = 3'd3,
        ST_LOADED    = 3'd4,
        ST_RUN       = 3'd5,
        ST_DONE      = 3'd6,
        ST_ERR       = 3'd7
    } ann_seq_state_t;

    // States that share the wait timer.
    function automatic logic is_wait_state(input ann_seq_state_t s);
        return (s == ST_WAIT_ACK) || (s == ST_WAIT_XFER) || (s == ST_RUN);
    endfunction

    // States in which a new start request is honoured.
    function automatic logic accepts_start(input ann_seq_state_t s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ann_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : ann_wait_timer
// Brief    : Saturating wait-cycle counter; expired once TIMEOUT is reached.
// Revision : 1.0
// ============================================================================
module ann_wait_timer
    import ann_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
)(
    input  logic clk,
    input  logic n_reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int               CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != LIMIT)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign expired = (r_count == LIMIT);

endmodule
`default_nettype wire

// File: rtl/ann_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ann_load_sequencer
// Brief    : Fetches every coefficient block over the bus, then starts the ANN
//            core and reports done or timeout.
// Revision : 1.0
// ============================================================================
module ann_load_sequencer
    import ann_ctrl_pkg::*;
#(
    parameter  int NUM_SEL = 4,
    parameter  int TIMEOUT = DEFAULT_TIMEOUT,
    localparam int SEL_W   = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1
)(
    input  logic              clk,
    input  logic              n_reset,
    input  logic              start_detecting,
    input  logic [ADDR_W-1:0] image_address,
    input  logic              bus_busy,
    input  logic              ann_done,
    output logic              request_coef,
    output logic [SEL_W-1:0]  coef_select,
    output logic [ADDR_W-1:0] bus_address,
    output logic              image_weights_loaded,
    output logic              ann_start,
    output logic              busy,
    output logic              done_processing,
    output logic              timeout_err
);

    localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(NUM_SEL - 1);
    localparam logic [SEL_W-1:0] FIRST_SEL = SEL_W'(COEF_SEL_IMAGE);

    ann_seq_state_t    r_state;
    ann_seq_state_t    w_next_state;
    logic [SEL_W-1:0]  w_next_sel;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_timer_clear;
    logic              w_timer_en;
    logic              w_expired;

    // Any state change restarts the count, so each wait state starts from 0.
    assign w_timer_clear = (w_next_state != r_state);
    assign w_timer_en    = is_wait_state(r_state);

    ann_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .n_reset (n_reset),
        .clear   (w_timer_clear),
        .enable  (w_timer_en),
        .expired (w_expired)
    );

    always_comb begin
        w_next_state = r_state;
        w_next_sel   = coef_select;
        w_next_addr  = bus_address;
        unique case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_detecting) begin
                    w_next_state = ST_REQ;
                    w_next_sel   = FIRST_SEL;
                    w_next_addr  = image_address;
                end
            end
            ST_REQ: begin
                w_next_state = ST_WAIT_ACK;
            end
            // The awaited event is tested before expiry so it wins a tie.
            ST_WAIT_ACK: begin
                if (bus_busy) begin
                    w_next_state = ST_WAIT_XFER;
                end else if (w_expired) begin
                    w_next_state = ST_ERR;
                end
            end
            ST_WAIT_XFER: begin
                if (!bus_busy) begin
                    if (coef_select == LAST_SEL) begin
                        w_next_state = ST_LOADED;
                    end else begin
                        w_next_state = ST_REQ;
                        w_next_sel   = coef_select + SEL_W'(1);
                    end
                end else if (w_expired) begin
                    w_next_state = ST_ERR;
                end
            end
            ST_LOADED: begin
                w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (ann_done) begin
                    w_next_state = ST_DONE;
                end else if (w_expired) begin
                    w_next_state = ST_ERR;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state              <= ST_IDLE;
            request_coef         <= 1'b0;
            coef_select          <= '0;
            bus_address          <= '0;
            image_weights_loaded <= 1'b0;
            ann_start            <= 1'b0;
            busy                 <= 1'b0;
            done_processing      <= 1'b0;
            timeout_err          <= 1'b0;
        end else begin
            r_state              <= w_next_state;
            request_coef         <= (w_next_state == ST_REQ);
            coef_select          <= w_next_sel;
            bus_address          <= w_next_addr;
            image_weights_loaded <= (w_next_state == ST_LOADED);
            ann_start            <= (w_next_state == ST_LOADED);
            busy                 <= !accepts_start(w_next_state);
            done_processing      <= (w_next_state == ST_DONE);
            timeout_err          <= (w_next_state == ST_ERR);
        end
    end

endmodule
`default_nettype wire

// File: doc/ann_load_sequencer.md
# ann_load_sequencer

Controller that sequences one complete inference of the ANN datapath. On a start request it drives the verification bus through every coefficient block (image, then weight banks) using the request/select/busy handshake. It then pulses the load-complete and start strobes into the ANN core, waits for the core to finish, and reports done or timeout. It sits between the board-level start/address inputs, the bus bridge and the ANN core.

## Interface
- `NUM_SEL`, default 4: number of coefficient blocks to fetch. Select 0 is the image; 1..NUM_SEL-1 are the weight banks.
- `TIMEOUT`, default 1023: maximum cycles allowed in any single wait state.
- `clk`  in  1  single system clock, rising edge.
- `n_reset`  in  1  asynchronous, active-low reset.
- `start_detecting`  in  1  start request; acted on only in IDLE, DONE or ERR.
- `image_address`  in  10  image slot to fetch; sampled when a start is accepted.
- `bus_busy`  in  1  bus bridge busy; high while a transfer is in flight.
- `ann_done`  in  1  ANN core finished; single-cycle pulse.
- `request_coef`  out  1  one-cycle transfer request to the bus bridge.
- `coef_select`  out  2  block being fetched (width is ceil(log2(NUM_SEL)) ≥ 1).
- `bus_address`  out  10  latched `image_address`, held stable for the whole run.
- `image_weights_loaded`  out  1  one-cycle pulse when all blocks are fetched.
- `ann_start`  out  1  one-cycle pulse into the ANN core, coincident with `image_weights_loaded`.
- `busy`  out  1  high in every state except IDLE, DONE and ERR.
- `done_processing`  out  1  high in DONE; held until the next accepted start.
- `timeout_err`  out  1  high in ERR; sticky until the next accepted start or reset.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset puts the FSM in IDLE with `sel`=0 and the counter at 0.
- States: IDLE, REQ, WAIT_ACK, WAIT_XFER, LOADED, RUN, DONE, ERR.
- Start acceptance, in IDLE, DONE or ERR: `start_detecting`=1 latches `image_address`, clears `sel`, `done_processing` and `timeout_err`, and goes to REQ.
- `start_detecting` is ignored in every other state.
- REQ (one cycle): `request_coef`=1 and `coef_select`=`sel`. Go to WAIT_ACK.
- WAIT_ACK: wait for `bus_busy`=1, then go to WAIT_XFER.
- WAIT_XFER: wait for `bus_busy`=0.
  - If `sel`=NUM_SEL-1, go to LOADED.
  - Otherwise increment `sel` and go to REQ.
- LOADED (one cycle): `image_weights_loaded`=1 and `ann_start`=1. Go to RUN.
- RUN: wait for `ann_done`=1, then go to DONE.
- Timeout: WAIT_ACK, WAIT_XFER and RUN each share a cycle counter that clears on state entry. If the counter reaches TIMEOUT, go to ERR.
- Simultaneous events: if the awaited event and the timeout occur in the same cycle, the event wins.
- `ann_done` outside RUN is ignored.
- Reset asserted mid-run returns the block to IDLE immediately (asynchronous). The bus transfer is abandoned with no further `request_coef`.

## Timing
- Start accepted at edge t:
  - `request_coef`=1 and `coef_select`=0 during cycle t+1.
  - `bus_busy` is first sampled at edge t+2. `bus_busy` high during the REQ cycle is not treated as an acknowledge.
- Bus turnaround: each block costs 1 (REQ) + N_ack + N_xfer cycles. The next REQ follows the cycle after `bus_busy` is sampled low.
- With a zero-latency bridge (busy high for exactly 1 cycle), total load = 3·NUM_SEL cycles. `image_weights_loaded` rises one cycle after the last busy-low sample.
- `done_processing` rises one cycle after `ann_done` is sampled.
- `coef_select` holds its value from REQ through WAIT_XFER. It changes only on entry to the next REQ.
- `bus_address` changes only on an accepted start.

## Structure
- Shared package `ann_ctrl_pkg` holds:
  - the `ann_seq_state_t` enum (8 states);
  - `COEF_SEL_IMAGE`=0;
  - the default TIMEOUT constant.
- One natural sub-module, `ann_wait_timer`: a counter with clear-on-entry, enable and a `expired` flag, TIMEOUT-parameterised. It is instantiated once.
- The FSM, select counter and address latch live in the top module.

## Test plan
- Reset then idle: all outputs read 0; `start_detecting` asserted with `image_address`=0x155 → `bus_address`=0x155. Bridge model acks in 1 cycle with busy=2 cycles → exactly 4 `request_coef` pulses with `coef_select` 0,1,2,3; `image_weights_loaded` and `ann_start` pulse together once.
- Core model pulses `ann_done` 40 cycles after `ann_start` → `done_processing`=1 the next cycle and stays high. A second `start_detecting` clears it and repeats the sequence.
- Bridge never raises busy after select 2 → `timeout_err`=1 exactly TIMEOUT+1 cycles after WAIT_ACK entry, with `busy`=0. A later start clears the error and a full run completes.
- `start_detecting` held high throughout a run, and `image_address` changed mid-run → no extra REQs; `bus_address` unchanged until DONE.
- `n_reset` pulsed low during WAIT_XFER of select 1 → all outputs 0 asynchronously; after release, no `request_coef` appears until a new start.
- Awaited event and timeout coinciding: `bus_busy` falls on the cycle the counter reaches TIMEOUT → no error; the sequence advances.
